seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor of the team's 8-bit combinational ALU.
- Keeps the same opcode map and 4-bit flag vector, generalised to WIDTH bits.
- Single-cycle logic/add/sub/shift ops; multiply is iterative shift-add and divide is iterative restoring division, behind a start/busy/done handshake.
- Sits between the register file and the writeback mux of the datapath; the controller issues one op at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 4..32).

Ports:
- clk  in  1  clock; rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  issue request; sampled only while busy=0.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- sel  in  4  opcode; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when result/flags become valid.
- result  out  WIDTH  registered result; held until the next done.
- flags  out  4  [3] underflow, [2] overflow, [1] carry, [0] zero; held with result.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, flags=0; internal accumulators cleared. Reset mid-operation aborts the op and produces no done pulse.
- Handshake: start accepted when state=IDLE or DONE. Operands and opcode are latched at acceptance, so input changes afterwards are ignored. start while busy=1 is ignored (not queued).
- States and transitions:
  - IDLE -> EXEC on start with sel in {0,1,4..B} or illegal.
  - IDLE -> MUL on start with sel=2.
  - IDLE -> DIV on start with sel=3.
  - EXEC -> DONE after 1 cycle.
  - MUL and DIV -> DONE after WIDTH iteration cycles.
  - DONE -> IDLE, or directly to EXEC/MUL/DIV if start is asserted in DONE (back-to-back issue).
- Latency, with start sampled at edge 0: single-cycle ops give done=1 after edge 1; MUL/DIV give done=1 after edge WIDTH+1. done is high for exactly one cycle, in state DONE.
- Opcodes:
  - 0 ADD: {carry,result}=a+b at WIDTH+1 bits.
  - 1 SUB: result=a-b mod 2^WIDTH; underflow=borrow (a<b).
  - 2 MUL: full 2*WIDTH product; result=low half; overflow=1 iff high half is nonzero.
  - 3 DIV: result=floor(a/b); underflow=1 iff a<b and b!=0. Divide by zero gives result=all ones, overflow=1, underflow=0; it still takes the full WIDTH cycles.
  - 4 SHL: result=a<<b. 5 SHR: result=a>>b (logical). For both, b>=WIDTH gives result=0.
  - 6 AND, 7 OR, 8 XOR, 9 XNOR, A NAND, B NOR: bitwise.
  - C..F illegal: result=0, flags=0 (zero flag NOT set), done still pulses after 1 cycle.
- Flags are computed fresh for every op, and all bits not defined for that opcode are 0. zero=1 iff final result==0 and sel<=B.
- result/flags change only in the cycle done rises and are stable otherwise; busy is low in DONE.
- MUL datapath: WIDTH-bit multiplicand, 2*WIDTH accumulator, one bit of b per cycle, LSB first.
- DIV datapath: WIDTH-bit remainder register; one quotient bit per cycle, MSB first; remainder discarded.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams OP_ADD..OP_NOR (0x0..0xB);
  - flag index constants FLG_UNDER=3, FLG_OVER=2, FLG_CARRY=1, FLG_ZERO=0;
  - state encoding IDLE/EXEC/MUL/DIV/DONE.
- Sub-module seq_alu_muldiv:
  - holds the iterative MUL/DIV datapath and its WIDTH-cycle counter;
  - interface: go, is_div, a, b -> fin, q_or_prod (2*WIDTH), div_zero.
- Top-level seq_alu holds the FSM, handshake, single-cycle ops and flag generation.

Test Plan (WIDTH=8):
- ADD a=0xFF, b=0x02 -> done one cycle after start; result=0x01, flags=0b0010.
- SUB a=0x03, b=0x05 -> result=0xFE, flags=0b1000; then SUB 0x05-0x05 -> result=0x00, flags=0b0001.
- MUL a=0xFF, b=0x02 -> done 9 cycles after start; result=0xFE, flags=0b0100; MUL 0x0F*0x11 -> 0xFF, flags=0b0000.
- DIV 0x64/0x07 -> result=0x0E, flags=0; DIV 0x03/0x09 -> 0x00, flags=0b1001; DIV 0x10/0x00 -> 0xFF, flags=0b0100.
- SHL a=0x81, b=0x08 -> 0x00, flags=0b0001; AND 0x0F,0xF0 -> 0x00, flags=0b0001; sel=0xD -> 0x00, flags=0b0000, done pulses.
- Start MUL, pulse start with other operands at cycle 3 -> ignored, original product returned; new MUL then rst at cycle 4 -> busy=0, result=0, no done; back-to-back start in DONE accepted with no idle cycle.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode map, flag bit positions and controller state encoding for seq_alu.
// Opcodes above OP_NOR are reserved and complete with result=0, flags=0.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;

  localparam int FLG_UNDER = 3;
  localparam int FLG_OVER  = 2;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_NOR);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Multiply keeps b in the low half (LSB first); divide keeps {remainder, dividend/quotient}.
module seq_alu_muldiv
  #(parameter int WIDTH = 8)
  (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 fin,
  output logic [2*WIDTH-1:0]   q_or_prod,
  output logic                 div_zero
  );

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH-1:0]   opnd_r;
  logic [CW-1:0]      cnt_r;
  logic               active_r;
  logic               is_div_r;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;

  // One iteration step: add-and-shift for multiply, trial subtract for divide
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    acc_next_s  = {(2*WIDTH){1'b0}};
    if (is_div_r) begin
      // Remainder stays below the divisor, so a set MSB means the trial went negative
      if (!div_trial_s[WIDTH]) begin
        acc_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Operand load on go, then WIDTH iterations counted down to completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
      is_div_r <= 1'b0;
    end else if (go) begin
      acc_r    <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      opnd_r   <= is_div ? b : a;
      cnt_r    <= CW'(WIDTH);
      active_r <= 1'b1;
      is_div_r <= is_div;
    end else if (active_r && (cnt_r != {CW{1'b0}})) begin
      acc_r    <= acc_next_s;
      cnt_r    <= cnt_r - CW'(1);
    end else if (fin) begin
      active_r <= 1'b0;
    end else begin
      active_r <= active_r;
    end
  end

  assign fin       = active_r && (cnt_r == {CW{1'b0}});
  assign q_or_prod = is_div_r ? {{WIDTH{1'b0}}, acc_r[WIDTH-1:0]} : acc_r;
  assign div_zero  = is_div_r && (opnd_r == {WIDTH{1'b0}});

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with start/busy/done handshake; single-cycle logic/arith ops
// plus iterative multiply and divide delegated to seq_alu_muldiv.
module seq_alu
  import seq_alu_pkg::*;
  #(parameter int WIDTH = 8)
  (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
  );

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [3:0]         sel_r;
  logic               accept_s;
  logic               md_go_s;
  logic               md_fin_s;
  logic               md_div_zero_s;
  logic [2*WIDTH-1:0] md_out_s;
  logic [WIDTH:0]     sum_s;
  logic               shift_big_s;
  logic [WIDTH-1:0]   res_s;
  logic [3:0]         flg_s;

  assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign md_go_s  = accept_s && ((sel == OP_MUL) || (sel == OP_DIV));

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .go        (md_go_s),
    .is_div    (sel == OP_DIV),
    .a         (a),
    .b         (b),
    .fin       (md_fin_s),
    .q_or_prod (md_out_s),
    .div_zero  (md_div_zero_s)
  );

  // Result and flags for the latched opcode; only sampled when entering DONE
  always_comb begin
    res_s       = {WIDTH{1'b0}};
    flg_s       = 4'b0000;
    sum_s       = {1'b0, a_r} + {1'b0, b_r};
    shift_big_s = (32'(b_r) >= WIDTH);
    case (sel_r)
      OP_ADD: begin
        res_s            = sum_s[WIDTH-1:0];
        flg_s[FLG_CARRY] = sum_s[WIDTH];
      end
      OP_SUB: begin
        res_s            = a_r - b_r;
        flg_s[FLG_UNDER] = (a_r < b_r);
      end
      OP_MUL: begin
        res_s           = md_out_s[WIDTH-1:0];
        flg_s[FLG_OVER] = |md_out_s[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        res_s            = md_out_s[WIDTH-1:0];
        flg_s[FLG_OVER]  = md_div_zero_s;
        flg_s[FLG_UNDER] = (a_r < b_r) && !md_div_zero_s;
      end
      OP_SHL: begin
        if (shift_big_s) begin
          res_s = {WIDTH{1'b0}};
        end else begin
          res_s = a_r << b_r;
        end
      end
      OP_SHR: begin
        if (shift_big_s) begin
          res_s = {WIDTH{1'b0}};
        end else begin
          res_s = a_r >> b_r;
        end
      end
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_XOR:  res_s = a_r ^ b_r;
      OP_XNOR: res_s = ~(a_r ^ b_r);
      OP_NAND: res_s = ~(a_r & b_r);
      OP_NOR:  res_s = ~(a_r | b_r);
      default: res_s = {WIDTH{1'b0}};
    endcase
    flg_s[FLG_ZERO] = op_is_legal(sel_r) && (res_s == {WIDTH{1'b0}});
  end

  // Controller FSM with registered handshake, result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= {WIDTH{1'b0}};
      flags   <= 4'b0000;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sel_r   <= 4'h0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r   <= a;
            b_r   <= b;
            sel_r <= sel;
            busy  <= 1'b1;
            if (sel == OP_MUL) begin
              state_r <= ST_MUL;
            end else if (sel == OP_DIV) begin
              state_r <= ST_DIV;
            end else begin
              state_r <= ST_EXEC;
            end
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          state_r <= ST_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          result  <= res_s;
          flags   <= flg_s;
        end
        ST_MUL, ST_DIV: begin
          if (md_fin_s) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= res_s;
            flags   <= flg_s;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): directed vector table, random ops against an
// arithmetic reference model, and hand-written handshake/reset corner sequences.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_res = '0;
  logic [3:0]   prev_flg = '0;

  typedef struct {
    logic [3:0]   s;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] r;
    logic [3:0]   f;
  } vec_t;

  vec_t vecs[16];

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .result (result),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference model straight from the opcode definitions using integer arithmetic
  function automatic void model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [3:0] f);
    int unsigned ix = x;
    int unsigned iy = y;
    int unsigned m  = 2 ** W;
    int unsigned full;
    f = 4'b0000;
    r = '0;
    case (s)
      4'h0: begin full = ix + iy; r = W'(full % m); f[1] = (full >= m); end
      4'h1: begin r = W'((ix + m - iy) % m); f[3] = (ix < iy); end
      4'h2: begin full = ix * iy; r = W'(full % m); f[2] = (full >= m); end
      4'h3: begin
        if (iy == 0) begin r = W'(m - 1); f[2] = 1'b1; end
        else begin r = W'(ix / iy); f[3] = (ix < iy); end
      end
      4'h4: r = (iy >= W) ? '0 : W'((ix * (2 ** iy)) % m);
      4'h5: r = (iy >= W) ? '0 : W'(ix / (2 ** iy));
      4'h6: r = x & y;
      4'h7: r = x | y;
      4'h8: r = x ^ y;
      4'h9: r = ~(x ^ y);
      4'hA: r = ~(x & y);
      4'hB: r = ~(x | y);
      default: r = '0;
    endcase
    if (s <= 4'hB) f[0] = (r == '0);
  endfunction

  task automatic run_op(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic [3:0] ef);
    int n;
    int exp_lat;
    exp_lat = (s == 4'h2 || s == 4'h3) ? W + 1 : 1;
    @(negedge clk);
    chk("done_single_pulse", 32'(done), 32'd0);
    sel = s; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("result_held", 32'(result), 32'(prev_res));
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("result", 32'(result), 32'(er));
    chk("flags", 32'(flags), 32'(ef));
    chk("busy_in_done", 32'(busy), 32'd0);
    prev_res = er;
    prev_flg = ef;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic [3:0]   rs;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         seen;
    int           n;

    vecs[0]  = '{4'h0, 8'hFF, 8'h02, 8'h01, 4'b0010};
    vecs[1]  = '{4'h1, 8'h03, 8'h05, 8'hFE, 4'b1000};
    vecs[2]  = '{4'h1, 8'h05, 8'h05, 8'h00, 4'b0001};
    vecs[3]  = '{4'h2, 8'hFF, 8'h02, 8'hFE, 4'b0100};
    vecs[4]  = '{4'h2, 8'h0F, 8'h11, 8'hFF, 4'b0000};
    vecs[5]  = '{4'h3, 8'h64, 8'h07, 8'h0E, 4'b0000};
    vecs[6]  = '{4'h3, 8'h03, 8'h09, 8'h00, 4'b1001};
    vecs[7]  = '{4'h3, 8'h10, 8'h00, 8'hFF, 4'b0100};
    vecs[8]  = '{4'h4, 8'h81, 8'h08, 8'h00, 4'b0001};
    vecs[9]  = '{4'h6, 8'h0F, 8'hF0, 8'h00, 4'b0001};
    vecs[10] = '{4'hD, 8'h12, 8'h34, 8'h00, 4'b0000};
    vecs[11] = '{4'h5, 8'h80, 8'h07, 8'h01, 4'b0000};
    vecs[12] = '{4'h9, 8'h0F, 8'h0F, 8'hFF, 4'b0000};
    vecs[13] = '{4'h0, 8'h80, 8'h80, 8'h00, 4'b0011};
    vecs[14] = '{4'h4, 8'h01, 8'h07, 8'h80, 4'b0000};
    vecs[15] = '{4'hF, 8'h00, 8'h00, 8'h00, 4'b0000};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].s, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].f);
    end

    for (int i = 0; i < 120; i++) begin
      rs = 4'($urandom_range(0, 15));
      rx = W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
      model(rs, rx, ry, er, ef);
      run_op(rs, rx, ry, er, ef);
    end

    // Start pulsed while a multiply is busy must be dropped
    @(negedge clk);
    sel = 4'h2; a = 8'h0F; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 2) begin
        start = 1'b1; sel = 4'h0; a = 8'h55; b = 8'h22;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("ignored_start_latency", 32'(n), 32'(W + 1));
    chk("ignored_start_result", 32'(result), 32'h0000_00FF);
    chk("ignored_start_flags", 32'(flags), 32'd0);
    prev_res = 8'hFF; prev_flg = 4'b0000;

    // Back-to-back issue from DONE with no idle cycle
    run_op(4'h0, 8'h10, 8'h20, 8'h30, 4'b0000);
    sel = 4'h1; a = 8'h09; b = 8'h04; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_latency", 32'(n), 32'd1);
    chk("b2b_result", 32'(result), 32'h0000_0005);
    chk("b2b_flags", 32'(flags), 32'd0);
    prev_res = 8'h05; prev_flg = 4'b0000;

    // Reset in the middle of a multiply aborts it silently
    @(negedge clk);
    sel = 4'h2; a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    prev_res = '0; prev_flg = '0;

    run_op(4'h3, 8'hC8, 8'h0A, 8'h14, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
